// File: rtl/mem_byte_port.sv
`default_nettype none
// ============================================================================
//  Module   : mem_byte_port
//  Purpose  : Datapath-side memory access unit for the LC-3b multicycle core.
//             Accepts one load/store request at a time, runs the
//             mem_read/mem_write/mem_resp handshake, builds the byte lane
//             mask for STB/STW, zero-extends LDB results and reports
//             misaligned word accesses and memory timeouts as errors.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    TIMEOUT  max ACCESS cycles to wait for mem_resp (0 = never time out)
//    CNT_W    wait counter width, TIMEOUT < 2**CNT_W
//  Ports
//    clk, reset        clock, synchronous active-high reset
//    req_*             request from datapath (valid/ready handshake)
//    rsp_*             one-cycle completion pulse, load data, error flag
//    mem_address/read/write/byte_enable/wdata   memory request side
//    mem_rdata/resp    memory completion side
// ============================================================================
module mem_byte_port #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  // datapath request
  input  logic        req_valid,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  // datapath response
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  // memory side
  output logic [15:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_byte_enable,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_resp
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2
  } state_e;

  // Counter value seen in the last ACCESS cycle before a timeout: the counter
  // is cleared on acceptance, so ACCESS cycle k observes k-1.  Only used when
  // TIMEOUT != 0, so the wrap of TIMEOUT-1 at zero is irrelevant.
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;
  localparam bit               C_TO_EN    = (TIMEOUT != 0);

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic              byte_q,  byte_d;
  logic [15:0]       addr_q,  addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              err_q,   err_d;

  logic [7:0]        w_sel_byte;
  logic              w_timeout;

  // Addressed byte of the returned word for LDB.
  assign w_sel_byte = addr_q[0] ? mem_rdata[15:8] : mem_rdata[7:0];
  // Timeout only fires when no response is present this cycle, which gives
  // mem_resp priority in the simultaneous case.
  assign w_timeout  = C_TO_EN && !mem_resp && (cnt_q == C_CNT_LAST);

  // ------------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      byte_q  <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      cnt_q   <= '0;
      rdata_q <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      byte_q  <= byte_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // ------------------------------------------------------------------------
  // Next state and outputs
  // ------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    write_d         = write_q;
    byte_d          = byte_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    cnt_d           = cnt_q;
    rdata_d         = rdata_q;
    err_d           = err_q;
    req_ready       = 1'b0;
    rsp_valid       = 1'b0;
    rsp_err         = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = 2'b00;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          write_d = req_write;
          byte_d  = req_byte;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = '0;
          // Misaligned word access never reaches memory.
          if (!req_byte && req_addr[0]) begin
            err_d   = 1'b1;
            state_d = ST_RESPOND;
          end else begin
            err_d   = 1'b0;
            state_d = ST_ACCESS;
          end
        end
      end

      ST_ACCESS: begin
        mem_read  = ~write_q;
        mem_write = write_q;
        // Only a byte store narrows the lane mask; the store byte is already
        // replicated on both halves of wdata.
        if (write_q && byte_q) begin
          mem_byte_enable = addr_q[0] ? 2'b10 : 2'b01;
        end else begin
          mem_byte_enable = 2'b11;
        end

        if (mem_resp) begin
          err_d   = 1'b0;
          state_d = ST_RESPOND;
          if (!write_q) begin
            rdata_d = byte_q ? {8'h00, w_sel_byte} : mem_rdata;
          end
        end else begin
          // Saturate instead of wrapping so TIMEOUT=0 stays harmless.
          if (cnt_q != C_CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (w_timeout) begin
            err_d   = 1'b1;
            state_d = ST_RESPOND;
          end
        end
      end

      ST_RESPOND: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rsp_rdata   = rdata_q;
  assign mem_address = {addr_q[15:1], 1'b0};
  assign mem_wdata   = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_byte_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_byte_port
//  Purpose  : Directed self-checking bench for mem_byte_port (TIMEOUT=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_byte_port;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic        req_byte = 1'b0;
  logic [15:0] req_addr = 16'h0;
  logic [15:0] req_wdata = 16'h0;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0;
  logic        mem_resp = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_byte_port #(
    .TIMEOUT (4),
    .CNT_W   (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_write       (req_write),
    .req_byte        (req_byte),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_ready       (req_ready),
    .rsp_valid       (rsp_valid),
    .rsp_rdata       (rsp_rdata),
    .rsp_err         (rsp_err),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp)
  );

  // Advance one clock and settle 1 time unit past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for exactly one edge (DUT is expected to be IDLE).
  // Returns in the first cycle after the acceptance edge.
  task automatic issue(input logic wr, input logic by, input logic [15:0] a,
                       input logic [15:0] wd);
    req_write = wr;
    req_byte  = by;
    req_addr  = a;
    req_wdata = wd;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp got v=%b e=%b exp=0,0", rsp_valid, rsp_err); end
    checks++; if (rsp_rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata got=%h exp=0000", rsp_rdata); end
    checks++; if ({mem_read, mem_write, mem_byte_enable} !== 4'b0000) begin errors++; $display("FAIL reset_strobes got=%b exp=0000", {mem_read, mem_write, mem_byte_enable}); end
    checks++; if (mem_address !== 16'h0 || mem_wdata !== 16'h0) begin errors++; $display("FAIL reset_addr_wdata got=%h/%h exp=0000/0000", mem_address, mem_wdata); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_word_load();
    issue(1'b0, 1'b0, 16'h1234, 16'h0);
    for (int k = 1; k <= 3; k++) begin
      checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin errors++; $display("FAIL wl_strobe cyc=%0d got r=%b w=%b exp r=1 w=0", k, mem_read, mem_write); end
      checks++; if (mem_address !== 16'h1234 || mem_byte_enable !== 2'b11) begin errors++; $display("FAIL wl_addr cyc=%0d got=%h be=%b exp=1234 be=11", k, mem_address, mem_byte_enable); end
      checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL wl_early cyc=%0d got v=%b rdy=%b exp 0,0", k, rsp_valid, req_ready); end
      if (k == 3) begin mem_resp = 1'b1; mem_rdata = 16'hBEEF; end
      tick();
      mem_resp = 1'b0;
    end
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin errors++; $display("FAIL wl_rsp got v=%b e=%b exp 1,0", rsp_valid, rsp_err); end
    checks++; if (rsp_rdata !== 16'hBEEF) begin errors++; $display("FAIL wl_rdata got=%h exp=beef", rsp_rdata); end
    checks++; if (mem_read !== 1'b0 || mem_byte_enable !== 2'b00) begin errors++; $display("FAIL wl_resp_strobe got r=%b be=%b exp 0,00", mem_read, mem_byte_enable); end
    tick();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL wl_idle got v=%b rdy=%b exp 0,1", rsp_valid, req_ready); end
  endtask

  task automatic test_byte_loads();
    logic [15:0] addrs [2];
    logic [15:0] exps  [2];
    addrs[0] = 16'h2001; exps[0] = 16'h00A5;
    addrs[1] = 16'h2000; exps[1] = 16'h005A;
    for (int i = 0; i < 2; i++) begin
      issue(1'b0, 1'b1, addrs[i], 16'h0);
      checks++; if (mem_address !== 16'h2000 || mem_byte_enable !== 2'b11 || mem_read !== 1'b1) begin errors++; $display("FAIL bl_access%0d got a=%h be=%b r=%b exp 2000,11,1", i, mem_address, mem_byte_enable, mem_read); end
      mem_resp = 1'b1; mem_rdata = 16'hA55A;
      tick();
      mem_resp = 1'b0;
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== exps[i] || rsp_err !== 1'b0) begin errors++; $display("FAIL bl_rsp%0d got v=%b d=%h e=%b exp 1,%h,0", i, rsp_valid, rsp_rdata, rsp_err, exps[i]); end
      tick();
    end
  endtask

  task automatic test_byte_stores();
    logic [15:0] addrs [2];
    logic [1:0]  bes   [2];
    addrs[0] = 16'h3001; bes[0] = 2'b10;
    addrs[1] = 16'h3000; bes[1] = 2'b01;
    for (int i = 0; i < 2; i++) begin
      issue(1'b1, 1'b1, addrs[i], 16'h7E7E);
      checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_byte_enable !== bes[i]) begin errors++; $display("FAIL bs_lane%0d got w=%b r=%b be=%b exp 1,0,%b", i, mem_write, mem_read, mem_byte_enable, bes[i]); end
      checks++; if (mem_wdata !== 16'h7E7E || mem_address !== 16'h3000) begin errors++; $display("FAIL bs_data%0d got d=%h a=%h exp 7e7e,3000", i, mem_wdata, mem_address); end
      mem_resp = 1'b1; mem_rdata = 16'hFFFF;
      tick();
      mem_resp = 1'b0;
      // A store leaves the previous load result in place.
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 16'h005A) begin errors++; $display("FAIL bs_rsp%0d got v=%b e=%b d=%h exp 1,0,005a", i, rsp_valid, rsp_err, rsp_rdata); end
      tick();
    end
  endtask

  task automatic test_misaligned();
    issue(1'b1, 1'b0, 16'h4003, 16'h1111);
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin errors++; $display("FAIL mis_rsp got v=%b e=%b exp 1,1", rsp_valid, rsp_err); end
    checks++; if ({mem_read, mem_write, mem_byte_enable} !== 4'b0000) begin errors++; $display("FAIL mis_strobe got=%b exp=0000", {mem_read, mem_write, mem_byte_enable}); end
    tick();
    checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL mis_after got v=%b e=%b w=%b exp 0,0,0", rsp_valid, rsp_err, mem_write); end
    // Aligned word store, response in the second ACCESS cycle.
    issue(1'b1, 1'b0, 16'h4002, 16'h1357);
    for (int k = 1; k <= 2; k++) begin
      checks++; if (mem_write !== 1'b1 || mem_byte_enable !== 2'b11 || mem_address !== 16'h4002 || mem_wdata !== 16'h1357) begin errors++; $display("FAIL ws_access cyc=%0d got w=%b be=%b a=%h d=%h exp 1,11,4002,1357", k, mem_write, mem_byte_enable, mem_address, mem_wdata); end
      if (k == 2) mem_resp = 1'b1;
      tick();
      mem_resp = 1'b0;
    end
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin errors++; $display("FAIL ws_rsp got v=%b e=%b exp 1,0", rsp_valid, rsp_err); end
    tick();
  endtask

  task automatic test_timeout();
    // Known load result first.
    issue(1'b0, 1'b0, 16'h5000, 16'h0);
    mem_resp = 1'b1; mem_rdata = 16'hC0DE;
    tick();
    mem_resp = 1'b0;
    tick();
    issue(1'b0, 1'b0, 16'h5100, 16'h0);
    for (int k = 1; k <= 4; k++) begin
      checks++; if (mem_read !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL to_wait cyc=%0d got r=%b v=%b exp 1,0", k, mem_read, rsp_valid); end
      tick();
    end
    checks++; if (mem_read !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin errors++; $display("FAIL to_rsp got r=%b v=%b e=%b exp 0,1,1", mem_read, rsp_valid, rsp_err); end
    checks++; if (rsp_rdata !== 16'hC0DE) begin errors++; $display("FAIL to_rdata got=%h exp=c0de", rsp_rdata); end
    tick();
    // Late response with no request outstanding must be ignored.
    mem_resp = 1'b1; mem_rdata = 16'hFFFF;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 16'hC0DE || req_ready !== 1'b1 || mem_read !== 1'b0) begin errors++; $display("FAIL to_late cyc=%0d got v=%b d=%h rdy=%b r=%b exp 0,c0de,1,0", k, rsp_valid, rsp_rdata, req_ready, mem_read); end
    end
    mem_resp = 1'b0;
  endtask

  task automatic test_simultaneous();
    issue(1'b0, 1'b0, 16'h5200, 16'h0);
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) begin mem_resp = 1'b1; mem_rdata = 16'h600D; end
      tick();
      mem_resp = 1'b0;
    end
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 16'h600D) begin errors++; $display("FAIL sim_rsp got v=%b e=%b d=%h exp 1,0,600d", rsp_valid, rsp_err, rsp_rdata); end
    tick();
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 1'b1, 16'h2001, 16'h0);
    // Next request presented immediately and held while busy.
    req_write = 1'b0; req_byte = 1'b0; req_addr = 16'h6000; req_valid = 1'b1;
    mem_resp = 1'b1; mem_rdata = 16'h1122;
    tick();
    mem_resp = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== 16'h0011) begin errors++; $display("FAIL b2b_rsp got v=%b rdy=%b d=%h exp 1,0,0011", rsp_valid, req_ready, rsp_rdata); end
    tick();
    checks++; if (req_ready !== 1'b1 || mem_read !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got rdy=%b r=%b v=%b exp 1,0,0", req_ready, mem_read, rsp_valid); end
    tick();
    req_valid = 1'b0;
    checks++; if (mem_read !== 1'b1 || mem_address !== 16'h6000 || req_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept got r=%b a=%h rdy=%b exp 1,6000,0", mem_read, mem_address, req_ready); end
    mem_resp = 1'b1; mem_rdata = 16'h3344;
    tick();
    mem_resp = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h3344) begin errors++; $display("FAIL b2b_rsp2 got v=%b d=%h exp 1,3344", rsp_valid, rsp_rdata); end
    tick();
  endtask

  task automatic test_reset_abort();
    issue(1'b0, 1'b0, 16'h7000, 16'h0);
    tick();
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL ra_access got r=%b exp 1", mem_read); end
    reset = 1'b1;
    tick();
    checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL ra_drop got r=%b w=%b v=%b exp 0,0,0", mem_read, mem_write, rsp_valid); end
    checks++; if (req_ready !== 1'b1 || rsp_rdata !== 16'h0000 || mem_address !== 16'h0000) begin errors++; $display("FAIL ra_state got rdy=%b d=%h a=%h exp 1,0000,0000", req_ready, rsp_rdata, mem_address); end
    reset = 1'b0;
    mem_resp = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (rsp_valid !== 1'b0 || mem_read !== 1'b0) begin errors++; $display("FAIL ra_quiet cyc=%0d got v=%b r=%b exp 0,0", k, rsp_valid, mem_read); end
    end
    mem_resp = 1'b0;
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_loads();
    test_byte_stores();
    test_misaligned();
    test_timeout();
    test_simultaneous();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
